prog_loader: RTL and testbench

- Writer side of the program-memory interface: the CPU only reads instruction words from progmem, and this block fills it.
- Takes a byte stream on a valid/ready handshake, assembles 16-bit instruction words (high byte first) and writes them to a writable progmem at consecutive addresses from 0.
- Holds the CPU in reset until the image is fully loaded, then releases it.

---
 rtl/prog_loader.sv | 178 +++++++++++++++++
 tb/tb_prog_loader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: frames SYNC_BYTE, 16-bit word count, then data words
// (high byte first) into progmem, holding the CPU in reset until loading completes.
// Optional trailing 16-bit checksum when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
   parameter int          ADDR_W    = 6,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              reload,
   output logic              pm_we,
   output logic [ADDR_W-1:0] pm_addr,
   output logic [15:0]       pm_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   typedef enum logic [3:0] {
      S_SYNC,
      S_LEN_HI,
      S_LEN_LO,
      S_DAT_HI,
      S_DAT_LO,
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK_HI,
      S_CHK_LO,
`endif
      S_DONE,
      S_ERR
   } state_t;

   // State entered once the data words (if any) have all been received.
`ifdef PROG_LOADER_CHECKSUM_EN
   localparam state_t S_FINISH = S_CHK_HI;
`else
   localparam state_t S_FINISH = S_DONE;
`endif

   localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

   state_t              state_reg, state_next;
   logic [7:0]          hi_reg, hi_next;
   logic [15:0]         remaining_reg, remaining_next;
   logic [ADDR_W-1:0]   idx_reg, idx_next;
   logic                pm_we_reg, pm_we_next;
   logic [ADDR_W-1:0]   pm_addr_reg, pm_addr_next;
   logic [15:0]         pm_wdata_reg, pm_wdata_next;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [15:0]         sum_reg, sum_next;
`endif

   logic                accept;
   logic [15:0]         byte_pair;
   logic [15:0]         count_w;

   assign in_ready  = (state_reg != S_DONE) && (state_reg != S_ERR);
   assign accept    = in_valid && in_ready;
   assign byte_pair = {hi_reg, in_data};
   assign count_w   = {remaining_reg[15:8], in_data};

   assign pm_we    = pm_we_reg;
   assign pm_addr  = pm_addr_reg;
   assign pm_wdata = pm_wdata_reg;
   assign cpu_hold = (state_reg != S_DONE);
   assign done     = (state_reg == S_DONE);
   assign error    = (state_reg == S_ERR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= S_SYNC;
         hi_reg        <= '0;
         remaining_reg <= '0;
         idx_reg       <= '0;
         pm_we_reg     <= 1'b0;
         pm_addr_reg   <= '0;
         pm_wdata_reg  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_reg       <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         hi_reg        <= hi_next;
         remaining_reg <= remaining_next;
         idx_reg       <= idx_next;
         pm_we_reg     <= pm_we_next;
         pm_addr_reg   <= pm_addr_next;
         pm_wdata_reg  <= pm_wdata_next;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_reg       <= sum_next;
`endif
      end
   end

   always_comb begin
      state_next     = state_reg;
      hi_next        = hi_reg;
      remaining_next = remaining_reg;
      idx_next       = idx_reg;
      pm_we_next     = 1'b0;
      pm_addr_next   = pm_addr_reg;
      pm_wdata_next  = pm_wdata_reg;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_next       = sum_reg;
`endif
      case (state_reg)
         S_SYNC: begin
            if (accept && in_data == SYNC_BYTE) begin
               state_next = S_LEN_HI;
               idx_next   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_next   = '0;
`endif
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               remaining_next = {in_data, remaining_reg[7:0]};
               state_next     = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               remaining_next = count_w;
               if (count_w == 16'd0)
                  state_next = S_FINISH;
               else if ({1'b0, count_w} > CAPACITY)
                  state_next = S_ERR;
               else
                  state_next = S_DAT_HI;
            end
         end
         S_DAT_HI: begin
            if (accept) begin
               hi_next    = in_data;
               state_next = S_DAT_LO;
            end
         end
         S_DAT_LO: begin
            // Write strobe is registered, so it is visible the cycle after the low byte.
            if (accept) begin
               pm_we_next     = 1'b1;
               pm_wdata_next  = byte_pair;
               pm_addr_next   = idx_reg;
               idx_next       = idx_reg + ADDR_W'(1);
               remaining_next = remaining_reg - 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_next       = sum_reg + byte_pair;
`endif
               state_next     = (remaining_reg == 16'd1) ? S_FINISH : S_DAT_HI;
            end
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         S_CHK_HI: begin
            if (accept) begin
               hi_next    = in_data;
               state_next = S_CHK_LO;
            end
         end
         S_CHK_LO: begin
            if (accept)
               state_next = (byte_pair == sum_reg) ? S_DONE : S_ERR;
         end
`endif
         S_DONE, S_ERR: begin
            if (reload) begin
               state_next   = S_SYNC;
               pm_addr_next = '0;
            end
         end
         default: state_next = S_SYNC;
      endcase
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed table, hand sequences for reload,
// async reset and full capacity, and random frames against a stream-parsing model.
module tb_prog_loader;
   localparam int ADDR_W = 6;
   localparam int CAP    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              reload;
   logic              pm_we;
   logic [ADDR_W-1:0] pm_addr;
   logic [15:0]       pm_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;

   prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .reload   (reload),
      .pm_we    (pm_we),
      .pm_addr  (pm_addr),
      .pm_wdata (pm_wdata),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];
   logic [7:0]  stim_q[$];
   int          exp_status;   // 0 = still loading, 1 = done, 2 = error

   always @(negedge clk)
      if (pm_we === 1'b1) got_q.push_back({16'(pm_addr), pm_wdata});

   typedef struct {
      int               n;
      logic [0:11][7:0] b;
      int               nw;
      logic             d;
      logic             e;
      logic [15:0]      last;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      reload   = 1'b0;
      #1 reset = 1'b1;
      #2 reset = 1'b0;
      got_q.delete();
      @(negedge clk);
   endtask

   // Called after a negedge; returns after a negedge. Gives up after 3 cycles of in_ready low.
   task automatic send(input logic [7:0] b);
      bit ok;
      ok       = 1'b0;
      in_data  = b;
      in_valid = 1'b1;
      for (int t = 0; t < 3 && !ok; t++) begin
         if (in_ready) begin
            @(posedge clk);
            ok = 1'b1;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_stream();
      for (int i = 0; i < stim_q.size(); i++) begin
         send(stim_q[i]);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   // Reference: parse the byte stream by the framing rules.
   task automatic model();
      int i;
      int cnt;
      logic [15:0] sum;
      logic [15:0] w;
      i   = 0;
      sum = 16'd0;
      exp_q.delete();
      exp_status = 0;
      while (i < stim_q.size() && stim_q[i] != 8'hA5) i++;
      if (i + 3 > stim_q.size()) return;
      cnt = int'({stim_q[i+1], stim_q[i+2]});
      i += 3;
      if (cnt > CAP) begin
         exp_status = 2;
         return;
      end
      for (int k = 0; k < cnt; k++) begin
         if (i + 2 > stim_q.size()) return;
         w = {stim_q[i], stim_q[i+1]};
         exp_q.push_back({16'(k), w});
         sum += w;
         i += 2;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if (i + 2 > stim_q.size()) return;
      exp_status = ({stim_q[i], stim_q[i+1]} == sum) ? 1 : 2;
`else
      exp_status = 1;
`endif
   endtask

   task automatic compare_run(input string tag);
      repeat (2) @(negedge clk);
      chk($sformatf("%s_nwrites", tag), 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
         chk($sformatf("%s_write%0d", tag, k), got_q[k], exp_q[k]);
      chk($sformatf("%s_done", tag), 32'(done), 32'(exp_status == 1));
      chk($sformatf("%s_error", tag), 32'(error), 32'(exp_status == 2));
      chk($sformatf("%s_hold", tag), 32'(cpu_hold), 32'(exp_status != 1));
      chk($sformatf("%s_ready", tag), 32'(in_ready), 32'(exp_status == 0));
   endtask

   initial begin
      logic [15:0] sum;
      int          cnt;
      int          r;

`ifdef PROG_LOADER_CHECKSUM_EN
      vt[0] = '{9, {72'hA5_00_02_00_01_00_02_00_03, 24'h0}, 2, 1'b1, 1'b0, 16'h0002};
      vt[1] = '{9, {72'hA5_00_02_00_01_00_02_00_04, 24'h0}, 2, 1'b0, 1'b1, 16'h0002};
      vt[2] = '{5, {40'hA5_00_00_00_00, 56'h0}, 0, 1'b1, 1'b0, 16'h0000};
      vt[3] = '{3, {24'hA5_00_41, 72'h0}, 0, 1'b0, 1'b1, 16'h0000};
      vt[4] = '{5, {40'h00_FF_A5_00_00, 56'h0}, 0, 1'b0, 1'b0, 16'h0000};
      vt[5] = '{7, {56'hA5_00_01_12_34_12_34, 40'h0}, 1, 1'b1, 1'b0, 16'h1234};
`else
      vt[0] = '{9, {72'hA5_00_03_8F_C8_00_02_8C_10, 24'h0}, 3, 1'b1, 1'b0, 16'h8C10};
      vt[1] = '{5, {40'h00_FF_A5_00_00, 56'h0}, 0, 1'b1, 1'b0, 16'h0000};
      vt[2] = '{3, {24'hA5_00_41, 72'h0}, 0, 1'b0, 1'b1, 16'h0000};
      vt[3] = '{5, {40'hA5_00_01_12_34, 56'h0}, 1, 1'b1, 1'b0, 16'h1234};
      vt[4] = '{5, {40'h12_A5_00_02_AB, 56'h0}, 0, 1'b0, 1'b0, 16'h0000};
      vt[5] = '{3, {24'hA5_01_00, 72'h0}, 0, 1'b0, 1'b1, 16'h0000};
`endif

      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      reload   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pm_we", 32'(pm_we), 32'd0);
      chk("rst_pm_addr", 32'(pm_addr), 32'd0);
      chk("rst_pm_wdata", 32'(pm_wdata), 32'd0);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      reset = 1'b0;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 6; i++) begin
         do_reset();
         for (int j = 0; j < vt[i].n; j++) begin
            send(vt[i].b[j]);
            if (j % 2 == 0) @(negedge clk);
         end
         repeat (2) @(negedge clk);
         chk($sformatf("tbl%0d_nwrites", i), 32'(got_q.size()), 32'(vt[i].nw));
         for (int k = 0; k < got_q.size() && k < vt[i].nw; k++)
            chk($sformatf("tbl%0d_addr%0d", i, k), 32'(got_q[k][31:16]), 32'(k));
         if (vt[i].nw > 0 && got_q.size() >= vt[i].nw)
            chk($sformatf("tbl%0d_last_data", i), 32'(got_q[vt[i].nw-1][15:0]), 32'(vt[i].last));
         chk($sformatf("tbl%0d_done", i), 32'(done), 32'(vt[i].d));
         chk($sformatf("tbl%0d_error", i), 32'(error), 32'(vt[i].e));
         chk($sformatf("tbl%0d_hold", i), 32'(cpu_hold), 32'(!vt[i].d));
         chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(!(vt[i].d || vt[i].e)));
      end

      // Oversize -> ERR, held in_valid ignored, reload recovers; reload mid-frame ignored
      do_reset();
      send(8'hA5); send(8'h00); send(8'h41);
      chk("ovr_error", 32'(error), 32'd1);
      chk("ovr_ready", 32'(in_ready), 32'd0);
      chk("ovr_hold", 32'(cpu_hold), 32'd1);
      in_data  = 8'hA5;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      chk("ovr_stall_error", 32'(error), 32'd1);
      chk("ovr_stall_writes", 32'(got_q.size()), 32'd0);
      pulse_reload();
      chk("rld_error", 32'(error), 32'd0);
      chk("rld_ready", 32'(in_ready), 32'd1);
      chk("rld_hold", 32'(cpu_hold), 32'd1);
      chk("rld_done", 32'(done), 32'd0);
      send(8'hA5);
      pulse_reload();
      send(8'h00); send(8'h01); send(8'hCA); send(8'hFE);
`ifdef PROG_LOADER_CHECKSUM_EN
      send(8'hCA); send(8'hFE);
`endif
      repeat (2) @(negedge clk);
      chk("rld_frame_writes", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) chk("rld_frame_word", got_q[0], 32'h0000_CAFE);
      chk("rld_frame_done", 32'(done), 32'd1);
      pulse_reload();
      chk("rld_done_cleared", 32'(done), 32'd0);
      chk("rld_pm_addr", 32'(pm_addr), 32'd0);

      // Full capacity, word k = k
      do_reset();
      send(8'hA5); send(8'h00); send(8'(CAP));
      sum = 16'd0;
      for (int k = 0; k < CAP; k++) begin
         send(8'h00); send(8'(k));
         sum += 16'(k);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send(sum[15:8]); send(sum[7:0]);
`endif
      repeat (2) @(negedge clk);
      chk("full_nwrites", 32'(got_q.size()), 32'(CAP));
      for (int k = 0; k < got_q.size(); k++)
         chk($sformatf("full_write%0d", k), got_q[k], {16'(k), 16'(k)});
      chk("full_done", 32'(done), 32'd1);
      chk("full_hold", 32'(cpu_hold), 32'd0);

      // Async reset between DAT_HI and DAT_LO of the third word
      do_reset();
      send(8'hA5); send(8'h00); send(8'h03);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(8'h55);
      #1 reset = 1'b1;
      #1;
      chk("arst_pm_addr", 32'(pm_addr), 32'd0);
      chk("arst_pm_wdata", 32'(pm_wdata), 32'd0);
      chk("arst_pm_we", 32'(pm_we), 32'd0);
      chk("arst_hold", 32'(cpu_hold), 32'd1);
      #1 reset = 1'b0;
      @(negedge clk);
      send(8'h66); send(8'h77); send(8'h00);
      repeat (3) @(negedge clk);
      chk("arst_nwrites", 32'(got_q.size()), 32'd2);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd1);

      // Random frames against the model
      for (int f = 0; f < 40; f++) begin
         stim_q.delete();
         repeat ($urandom_range(0, 2)) begin
            r = $urandom_range(0, 255);
            stim_q.push_back(r == 8'hA5 ? 8'h00 : 8'(r));
         end
         stim_q.push_back(8'hA5);
         r = $urandom_range(0, 9);
         cnt = (r == 0) ? 0 : (r == 1) ? $urandom_range(CAP + 1, 400) :
               (r == 2) ? CAP : $urandom_range(1, 8);
         stim_q.push_back(8'(cnt >> 8));
         stim_q.push_back(8'(cnt));
         if (cnt <= CAP) begin
            sum = 16'd0;
            for (int k = 0; k < cnt; k++) begin
               logic [15:0] w;
               w = 16'($urandom);
               stim_q.push_back(w[15:8]);
               stim_q.push_back(w[7:0]);
               sum += w;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) sum ^= 16'(1 << $urandom_range(0, 15));
            stim_q.push_back(sum[15:8]);
            stim_q.push_back(sum[7:0]);
`endif
            if ($urandom_range(0, 9) == 0 && stim_q.size() > 4) void'(stim_q.pop_back());
         end
         do_reset();
         model();
         send_stream();
         compare_run($sformatf("rnd%0d", f));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
